// File: rtl/cis_pattern_loader.sv
// Pattern writer for CIS_Control: streams configuration words into a shadow bank and
// copies that bank to the active pattern_data bank only while the sequencer is idle.
module cis_pattern_loader #(
  parameter int NUM_SIGNALS = 8,
  parameter int PATTERN_LEN = 210,
  parameter int WORD_W      = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   load_start,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [WORD_W-1:0]                      wr_data,
  input  logic                                   commit,
  input  logic                                   running,
  output logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_data,
  output logic                                   load_done,
  output logic                                   commit_pending,
  output logic                                   committed,
  output logic                                   err
);

  localparam int WPS = (PATTERN_LEN + WORD_W - 1) / WORD_W;
  localparam int SW  = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
  localparam int WW  = (WPS > 1) ? $clog2(WPS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FULL} state_t;

  state_t                                  r_state;
  logic [SW-1:0]                           r_sig;
  logic [WW-1:0]                           r_word;
  logic                                    r_wr_ready;
  logic                                    r_load_done;
  logic                                    r_pending;
  logic                                    r_committed;
  logic                                    r_err;
  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] r_shadow;
  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] r_active;

  logic w_xfer;
  logic w_wr_en;
  logic w_last_word;
  logic w_last_sig;
  logic w_copy;

  assign w_xfer      = wr_valid && r_wr_ready;
  // A word arriving together with load_start belongs to neither load and is dropped.
  assign w_wr_en     = w_xfer && !load_start;
  assign w_last_word = (r_word == WW'(WPS - 1));
  assign w_last_sig  = (r_sig == SW'(NUM_SIGNALS - 1));
  assign w_copy      = (r_state == ST_FULL) && !load_start && !running && (r_pending || commit);

  // Bits of the last word of a row that fall beyond PATTERN_LEN have no home and are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_wr_en) begin
      for (int s = 0; s < NUM_SIGNALS; s++) begin
        for (int b = 0; b < PATTERN_LEN; b++) begin
          if (r_sig == SW'(s) && r_word == WW'(b / WORD_W)) begin
            r_shadow[s][b] <= wr_data[b % WORD_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_sig       <= '0;
      r_word      <= '0;
      r_wr_ready  <= 1'b0;
      r_load_done <= 1'b0;
      r_pending   <= 1'b0;
      r_committed <= 1'b0;
      r_err       <= 1'b0;
      r_active    <= '0;
    end else begin
      r_committed <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_err <= commit;
          if (load_start) begin
            r_state    <= ST_LOAD;
            r_sig      <= '0;
            r_word     <= '0;
            r_wr_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_err <= commit;
          if (load_start) begin
            r_sig  <= '0;
            r_word <= '0;
          end else if (w_xfer) begin
            if (w_last_word) begin
              r_word <= '0;
              if (w_last_sig) begin
                r_state     <= ST_FULL;
                r_wr_ready  <= 1'b0;
                r_load_done <= 1'b1;
              end else begin
                r_sig <= r_sig + 1'b1;
              end
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (load_start) begin
            if (r_pending) begin
              r_err <= 1'b1;
            end else begin
              // Restarting drops any same-cycle commit, which is illegal in LOAD.
              r_state     <= ST_LOAD;
              r_sig       <= '0;
              r_word      <= '0;
              r_wr_ready  <= 1'b1;
              r_load_done <= 1'b0;
              r_err       <= commit;
            end
          end else if (w_copy) begin
            r_active    <= r_shadow;
            r_committed <= 1'b1;
            r_pending   <= 1'b0;
            r_load_done <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (commit) begin
            r_pending <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_ready       = r_wr_ready;
  assign load_done      = r_load_done;
  assign commit_pending = r_pending;
  assign committed      = r_committed;
  assign err            = r_err;
  assign pattern_data   = r_active;

endmodule

// File: doc/cis_pattern_loader.md
Name: cis_pattern_loader

Overview:
- Writer side of the CIS_Control pattern interface: builds the NUM_SIGNALS x PATTERN_LEN pattern_data array that CIS_Control plays out.
- Accepts configuration words over a valid/ready stream into a shadow bank.
- Copies the shadow bank into the active pattern_data bank only while CIS_Control is not running, so a pattern never changes mid-sequence.

Parameters:
- NUM_SIGNALS, 8, number of pattern rows (CIS signals).
- PATTERN_LEN, 210, bits per pattern row (clock ticks).
- WORD_W, 16, width of one configuration word.
- Derived: WPS = ceil(PATTERN_LEN/WORD_W) words per signal (14 at defaults); TOTAL = NUM_SIGNALS*WPS words (112 at defaults).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse: begin a new shadow load.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  loader accepts wr_data this cycle.
- wr_data  in  WORD_W  configuration word.
- commit  in  1  one-cycle pulse: request shadow-to-active copy.
- running  in  1  CIS_Control busy flag.
- pattern_data  out  NUM_SIGNALS x PATTERN_LEN  active bank, driven to CIS_Control.
- load_done  out  1  shadow bank is complete (all TOTAL words received).
- commit_pending  out  1  commit accepted, waiting for running==0.
- committed  out  1  one-cycle pulse when the active bank updates.
- err  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset is asynchronous, active-low; one clock. On reset:
  - State is IDLE.
  - pattern_data, shadow bank, word and signal counters, wr_ready, load_done, commit_pending, committed and err are all 0.
- Word mapping: the k-th accepted word (k = s*WPS + w) goes to shadow[s][w*WORD_W +: WORD_W].
  - Bits at or above PATTERN_LEN are discarded.
  - At defaults, word 13 keeps only bits [1:0].
- Signal order: row 0 first; inside a row, LSB word first, matching CIS_Control's LSB-first playout.
- A transfer occurs when wr_valid && wr_ready. wr_ready is a registered output and is 1 only in state LOAD.
- States:
  - IDLE: wr_ready=0. load_start → LOAD (counters cleared).
  - LOAD: wr_ready=1.
    - Each transfer increments w.
    - When w==WPS-1, w wraps to 0 and s increments.
    - The transfer at s==NUM_SIGNALS-1, w==WPS-1 → FULL; wr_ready drops the next cycle and load_done=1 the next cycle.
  - FULL: wr_ready=0, load_done=1.
    - commit with running==0: pattern_data <= shadow on the next edge; committed pulses that cycle; state → IDLE; load_done cleared.
    - commit with running==1: commit_pending=1.
    - While pending, on the first cycle running==0: perform the copy, pulse committed, clear commit_pending, → IDLE.
- Commit latency:
  - 1 cycle from the commit pulse when idle.
  - 1 cycle after running falls when pending.
- The shadow bank persists after commit. A new load overwrites words as they arrive.
- Boundary conditions:
  - load_start in LOAD: restart at s=0, w=0; partial shadow contents are not cleared; no error.
  - load_start in FULL with commit_pending=0: restart load, load_done cleared.
  - load_start while commit_pending=1: ignored, err pulse.
  - commit in IDLE or LOAD: ignored, err pulse; pattern_data unchanged.
  - commit while already pending: no effect, no error.
  - load_start and commit in the same cycle: load_start wins by the rules above; commit is dropped; err pulses only if the commit would itself be illegal in the resulting state.
  - wr_valid while wr_ready=0: word not consumed; no error.
  - pattern_data changes only on a committed cycle, never while running==1.
  - reset_n asserted mid-load or mid-pending: everything returns to reset values; the active bank is cleared to 0.

Test Plan:
- Defaults:
  - Reset, load_start, then 112 words with wr_valid held high, where word k = 16'hA500+k, then commit with running=0.
  - Required response:
    - wr_ready deasserts after word 111.
    - load_done=1.
    - committed pulses one cycle after commit.
    - pattern_data[0][15:0]=16'hA500.
    - pattern_data[1][15:0]=16'hA50E.
    - pattern_data[7][209:208]=2'b11 (from word 16'hA56F).
- Pending commit:
  - Load a full pattern, hold running=1, pulse commit.
  - Required response: commit_pending=1 and pattern_data unchanged for 20 cycles; drop running → committed pulses one cycle later and commit_pending clears.
- Backpressure and gaps:
  - Random wr_valid toggling during the load.
  - Required response: exactly 112 transfers counted; final contents match the in-order mapping.
- Illegal requests:
  - commit after only 50 words → err pulse, pattern_data stays 0.
  - load_start while commit_pending=1 → err pulse, load_done remains 1.
- Restart:
  - load_start after 30 words, then 112 words of 16'hFFFF, then commit.
  - Required response: every pattern row equals all-ones across PATTERN_LEN bits.
- Asynchronous reset:
  - Assert reset_n=0 between clock edges during LOAD and during pending.
  - Required response: outputs clear immediately; wr_ready=0; pattern_data=0; state IDLE after release.
